axis_traffic_gen: RTL
=====================

# axis_traffic_gen

Parametrised AXI-Stream traffic generator and receive checker for the NoC mesh, replacing the single-stream number generator at each mesh endpoint. The transmit side issues a programmed number of multi-flit packets with LFSR payloads, rotating the destination across mesh nodes, with an optional inter-packet gap. The receive side sinks mesh output traffic, counts packets and flags packets whose length differs from the expected length. One instance sits on each router port: master to `axis_in_*`, slave from `axis_out_*`.

## Interface

- TDATAW, 32: data width.
- TDESTW, 4: destination width.
- LFSR_DW, 32: LFSR width.
- LFSR_DEFAULT, 32'hACE1_0001: LFSR seed, must be nonzero.
- LFSR_TAPS, 32'h8020_0003: Fibonacci feedback tap mask.
- SRC_ID, 0: this node's mesh address.
- NUM_DEST, 4: destinations cycled, 0..NUM_DEST-1. Range 1..2^TDESTW.
- SKIP_SELF, 1: if 1, the destination sequence never equals SRC_ID. Requires NUM_DEST ≥ 2 when SKIP_SELF=1.
- PKT_LEN, 4: flits per packet, ≥1.
- NUM_PKTS, 8: packets per START, ≥1.
- GAP, 0: idle cycles between packets.
- CNTW, 16: width of the RX counters.

Ports:

- CLK  in  1  clock.
- RST_N  in  1  synchronous reset, active low.
- START  in  1  one-cycle launch pulse.
- BUSY  out  1  transmit burst in progress.
- DONE  out  1  high after the last flit is accepted, until the next accepted START.
- AXIS_M_TVALID / TREADY / TDATA / TLAST / TDEST  out/in/out/out/out  1/1/TDATAW/1/TDESTW  master stream.
- AXIS_S_TVALID / TREADY / TDATA / TLAST / TDEST  in/out/in/in/in  1/1/TDATAW/1/TDESTW  slave stream.
- RX_PKT_CNT  out  CNTW  received packets (beats with TLAST).
- RX_ERR_CNT  out  CNTW  received packets with length ≠ PKT_LEN.

## Operation

- TX FSM states: IDLE, SEND, GAP, FIN.
  - IDLE: on START, load LFSR=LFSR_DEFAULT, set pkt=0, flit=0, dest=first valid destination, then go to SEND.
  - SEND: TVALID=1. Each accepted beat (TVALID&TREADY) advances the LFSR and increments flit.
  - On the beat with flit==PKT_LEN-1: TLAST=1, flit←0, pkt+1, dest advances.
  - Packet done, pkt==NUM_PKTS: go to FIN.
  - Packet done, GAP>0: go to GAP.
  - Packet done, GAP=0: stay in SEND with no bubble.
  - GAP: TVALID=0 for exactly GAP cycles, then SEND.
  - FIN: DONE=1, BUSY=0. Go to IDLE (DONE held) on the next cycle. START in FIN or IDLE relaunches.
- START while BUSY is ignored.
- BUSY = state ∈ {SEND, GAP}.
- LFSR next = {lfsr[LFSR_DW-2:0], ^(lfsr & LFSR_TAPS)}.
- TDATA = lfsr, zero-extended or truncated to TDATAW.
- Destination sequence: dest ← (dest+1) mod NUM_DEST. If SKIP_SELF and the result == SRC_ID, advance once more, within the same cycle.
  - The first valid destination is 0, or 1 if SKIP_SELF and SRC_ID==0.
- RX: AXIS_S_TREADY=1 whenever out of reset.
  - A beat counter increments per accepted beat.
  - On a TLAST beat: RX_PKT_CNT+1. If beats≠PKT_LEN, RX_ERR_CNT+1. The beat counter then clears.
  - A beat count exceeding PKT_LEN without TLAST counts one error at the eventual TLAST, not per beat.
  - Both counters saturate at 2^CNTW-1.
- RX and TX are independent. Loopback (TDEST==SRC_ID) is legal.

## Timing

- Reset values:
  - TVALID 0, TDATA 0, TLAST 0, TDEST 0.
  - BUSY 0, DONE 0, S_TREADY 0.
  - RX_PKT_CNT 0, RX_ERR_CNT 0.
  - Internal: LFSR=LFSR_DEFAULT, state IDLE.
- All outputs are registered.
- START sampled at edge n → TVALID, BUSY high after edge n+1. DONE clears at the same edge.
- Under backpressure, TDATA/TDEST/TLAST are held stable while TVALID&!TREADY. TVALID never drops before acceptance.
- With continuous TREADY and GAP=0, the burst takes NUM_PKTS×PKT_LEN cycles.
  - Each GAP adds GAP cycles between packets, (NUM_PKTS-1)×GAP in total.
  - DONE rises the cycle after the last accepted beat.
- PKT_LEN=1: every beat has TLAST=1.
- Reset mid-packet: TVALID drops at the reset edge. Any partial RX packet is discarded without an error count.
- Counter saturation: holds at max. No wrap.

## Test plan

- Default params, SRC_ID=0, TREADY=1, START pulse:
  - 32 consecutive beats, TLAST on beats 4, 8, …, 32.
  - TDEST sequence 1,2,3,1,2,3,1,2.
  - First TDATA 32'hACE1_0001.
  - DONE rises the cycle after beat 32, BUSY low.
- Random TREADY deassertion (~50%):
  - TDATA/TDEST/TLAST stable while stalled.
  - Payload sequence identical to the no-stall run.
- GAP=3: exactly 3 TVALID-low cycles between packets, none after the last packet. Burst length 32+21 cycles.
- RX: drive packets of 4, 3, 4 and 6 beats:
  - RX_PKT_CNT=4, RX_ERR_CNT=2.
  - TREADY stays high.
- START during SEND: no effect. Reset asserted at beat 10:
  - All outputs return to reset values next edge.
  - A subsequent START replays from LFSR_DEFAULT.
- Mesh integration, 2×2 with two generators at SRC_ID 0 and 2: total RX_PKT_CNT across nodes = 16, all RX_ERR_CNT = 0.

Source files
------------

// File: rtl/axis_traffic_gen_if.sv
// AXI-Stream bundle shared by the traffic generator's transmit and receive sides.
interface axis_traffic_gen_if #(
   parameter int TDATAW = 32,
   parameter int TDESTW = 4
);
   logic              tvalid;
   logic              tready;
   logic [TDATAW-1:0] tdata;
   logic              tlast;
   logic [TDESTW-1:0] tdest;

   modport master (output tvalid, tdata, tlast, tdest, input tready);
   modport slave  (input tvalid, tdata, tlast, tdest, output tready);
endinterface

// File: rtl/axis_traffic_gen.sv
// Mesh endpoint: bursts LFSR-payload packets to rotating destinations and
// counts / length-checks packets arriving from the mesh.
module axis_traffic_gen #(
   parameter int                 TDATAW       = 32,
   parameter int                 TDESTW       = 4,
   parameter int                 LFSR_DW      = 32,
   parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = LFSR_DW'(32'hACE1_0001),
   parameter logic [LFSR_DW-1:0] LFSR_TAPS    = LFSR_DW'(32'h8020_0003),
   parameter int                 SRC_ID       = 0,
   parameter int                 NUM_DEST     = 4,
   parameter int                 SKIP_SELF    = 1,
   parameter int                 PKT_LEN      = 4,
   parameter int                 NUM_PKTS     = 8,
   parameter int                 GAP          = 0,
   parameter int                 CNTW         = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  START,
   output logic                  BUSY,
   output logic                  DONE,
   axis_traffic_gen_if.master    axis_m,
   axis_traffic_gen_if.slave     axis_s,
   output logic [CNTW-1:0]       RX_PKT_CNT,
   output logic [CNTW-1:0]       RX_ERR_CNT
);

   localparam int FLW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int PKW = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
   localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int RBW = $clog2(PKT_LEN + 1);

   localparam logic [FLW-1:0]    FLIT_LAST  = FLW'(PKT_LEN - 1);
   localparam logic [PKW-1:0]    PKT_LAST   = PKW'(NUM_PKTS - 1);
   localparam logic [GW-1:0]     GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [RBW-1:0]    RX_LEN_M1  = RBW'(PKT_LEN - 1);
   localparam logic [RBW-1:0]    RX_SAT     = RBW'(PKT_LEN);
   localparam logic [TDESTW:0]   NDEST      = (TDESTW+1)'(NUM_DEST);
   localparam logic [TDESTW:0]   SRC        = (TDESTW+1)'(SRC_ID);
   localparam logic [TDESTW-1:0] DEST_FIRST = (SKIP_SELF != 0 && SRC_ID == 0) ?
                                              TDESTW'(1) : TDESTW'(0);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

   state_t             state, state_nx;
   logic               start_q;
   logic [LFSR_DW-1:0] lfsr, lfsr_nx;
   logic [FLW-1:0]     flit;
   logic [PKW-1:0]     pkt;
   logic [GW-1:0]      gap_cnt;
   logic               accept, pkt_end, load;
   logic [RBW-1:0]     rx_beats;
   logic               unused_rx;

   function automatic logic [TDATAW-1:0] fit_data(input logic [LFSR_DW-1:0] v);
      logic [TDATAW-1:0] r;
      r = '0;
      for (int i = 0; i < TDATAW; i++)
         if (i < LFSR_DW) r[i] = v[i];
      return r;
   endfunction

   // Modular increment that hops over our own address in the same cycle.
   function automatic logic [TDESTW-1:0] dest_adv(input logic [TDESTW-1:0] d);
      logic [TDESTW:0] n;
      n = {1'b0, d} + 1'b1;
      if (n >= NDEST) n = '0;
      if (SKIP_SELF != 0 && n == SRC) begin
         n = n + 1'b1;
         if (n >= NDEST) n = '0;
      end
      return n[TDESTW-1:0];
   endfunction

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   assign lfsr_nx = {lfsr[LFSR_DW-2:0], ^(lfsr & LFSR_TAPS)};
   assign accept  = (state == S_SEND) && axis_m.tvalid && axis_m.tready;
   assign pkt_end = accept && (flit == FLIT_LAST);
   assign load    = start_q && (state == S_IDLE || state == S_FIN);

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start_q) state_nx = S_SEND;
         S_SEND: begin
            if (pkt_end) begin
               if (pkt == PKT_LAST) state_nx = S_FIN;
               else if (GAP > 0)    state_nx = S_GAP;
            end
         end
         S_GAP:   if (gap_cnt == GAP_LAST) state_nx = S_SEND;
         S_FIN:   state_nx = start_q ? S_SEND : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // START is registered once, so the launch shows up two edges after the pulse.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         start_q       <= 1'b0;
         lfsr          <= LFSR_DEFAULT;
         flit          <= '0;
         pkt           <= '0;
         gap_cnt       <= '0;
         axis_m.tvalid <= 1'b0;
         axis_m.tdata  <= '0;
         axis_m.tlast  <= 1'b0;
         axis_m.tdest  <= '0;
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
      end else begin
         start_q       <= START && !BUSY;
         axis_m.tvalid <= (state_nx == S_SEND);
         BUSY          <= (state_nx == S_SEND) || (state_nx == S_GAP);
         DONE          <= (state_nx == S_FIN) || (DONE && !load);
         gap_cnt       <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
         if (load) begin
            lfsr         <= LFSR_DEFAULT;
            axis_m.tdata <= fit_data(LFSR_DEFAULT);
            flit         <= '0;
            pkt          <= '0;
            axis_m.tdest <= DEST_FIRST;
            axis_m.tlast <= (PKT_LEN == 1);
         end else if (accept) begin
            lfsr         <= lfsr_nx;
            axis_m.tdata <= fit_data(lfsr_nx);
            if (pkt_end) begin
               flit         <= '0;
               pkt          <= pkt + 1'b1;
               axis_m.tdest <= dest_adv(axis_m.tdest);
               axis_m.tlast <= (PKT_LEN == 1);
            end else begin
               flit         <= flit + 1'b1;
               axis_m.tlast <= (flit + 1'b1 == FLIT_LAST);
            end
         end
      end
   end

   // Receive payload and destination are only sunk, never inspected.
   assign unused_rx = ^{axis_s.tdata, axis_s.tdest};

   // Beat counter parks at PKT_LEN so an overlong packet still reads as wrong length.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         axis_s.tready <= 1'b0;
         rx_beats      <= '0;
         RX_PKT_CNT    <= '0;
         RX_ERR_CNT    <= '0;
      end else begin
         axis_s.tready <= 1'b1;
         if (axis_s.tvalid && axis_s.tready) begin
            if (axis_s.tlast) begin
               rx_beats   <= '0;
               RX_PKT_CNT <= sat_inc(RX_PKT_CNT);
               if (rx_beats != RX_LEN_M1) RX_ERR_CNT <= sat_inc(RX_ERR_CNT);
            end else if (rx_beats != RX_SAT) begin
               rx_beats <= rx_beats + 1'b1;
            end
         end
      end
   end

endmodule
